// File: rtl/keypad_item_entry_pkg.sv
// Shared key codes, entry-state encoding and accumulator sizing for the front-panel keypad.
package vm_keypad_pkg;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   typedef enum logic {
      ENTRY_IDLE   = 1'b0,
      ENTRY_ACTIVE = 1'b1
   } entry_state_e;

   // Bits needed to hold any value of up to max_digits decimal digits.
   function automatic int acc_width(input int max_digits);
      longint limit;
      limit = 1;
      for (int i = 0; i < max_digits; i++) begin
         limit = limit * 10;
      end
      return $clog2(limit);
   endfunction

endpackage

// File: rtl/keypad_item_entry_timer.sv
// Inactivity timer for a keypad entry: expires after TIMEOUT_CYCLES enabled cycles with no restart.
module entry_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rstn,
   input  logic enable,
   input  logic restart,
   output logic expire
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] count;

   // Held at zero outside an entry so every new entry starts from a fresh count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (!enable || restart || expire) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable && !restart && (count == LAST);

endmodule

// File: rtl/keypad_item_entry.sv
// Keypad decoder: accumulates decimal digits into an item number and issues legal numbers downstream.
module keypad_item_entry
   import vm_keypad_pkg::*;
#(
   parameter int ITEM_ADDR_WIDTH = 10,
   parameter int MAX_DIGITS      = 3,
   parameter int NUM_ITEMS       = 1000,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               key_valid,
   input  logic [3:0]                         key_code,
   output logic [ITEM_ADDR_WIDTH-1:0]         item_select,
   output logic                               item_select_valid,
   output logic                               entry_error,
   output logic                               entry_timeout,
   output logic                               entry_active,
   output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count
);

   localparam int ACC_W  = acc_width(MAX_DIGITS);
   localparam int CALC_W = ACC_W + 4;
   localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
   localparam logic [CALC_W-1:0] NUM_ITEMS_C  = CALC_W'(NUM_ITEMS);
   localparam logic [CNT_W-1:0]  MAX_DIGITS_C = CNT_W'(MAX_DIGITS);

   entry_state_e               state_q, state_d;
   logic [ACC_W-1:0]           acc_q, acc_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [ITEM_ADDR_WIDTH-1:0] sel_q, sel_d;
   logic                       valid_q, valid_d;
   logic                       error_q, error_d;
   logic                       timeout_q, timeout_d;
   logic                       is_digit, is_clear, is_enter, restart, expire;

   assign is_digit = key_valid && (key_code <= 4'd9);
   assign is_clear = key_valid && (key_code == KEY_CLEAR);
   assign is_enter = key_valid && (key_code == KEY_ENTER);
   // Codes 0xC-0xF are meaningless, so they must not keep an abandoned entry alive.
   assign restart  = key_valid && (key_code <= KEY_ENTER);

   entry_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rstn   (rstn),
      .enable (state_q == ENTRY_ACTIVE),
      .restart(restart),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ENTRY_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         sel_q     <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         timeout_q <= timeout_d;
      end
   end

   // A real key always takes priority over a timer expiry landing in the same cycle.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      valid_d   = 1'b0;
      error_d   = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         ENTRY_IDLE: begin
            if (is_digit) begin
               state_d = ENTRY_ACTIVE;
               acc_d   = ACC_W'(key_code);
               cnt_d   = CNT_W'(1);
            end
         end
         ENTRY_ACTIVE: begin
            if (is_digit) begin
               if (cnt_q < MAX_DIGITS_C) begin
                  acc_d = ACC_W'(({4'b0000, acc_q} * CALC_W'(10)) + CALC_W'(key_code));
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  error_d = 1'b1;
                  state_d = ENTRY_IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
               end
            end else if (is_clear || is_enter) begin
               if (is_enter) begin
                  if ({4'b0000, acc_q} < NUM_ITEMS_C) begin
                     sel_d   = ITEM_ADDR_WIDTH'(acc_q);
                     valid_d = 1'b1;
                  end else begin
                     error_d = 1'b1;
                  end
               end
               state_d = ENTRY_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end else if (expire) begin
               timeout_d = 1'b1;
               state_d   = ENTRY_IDLE;
               acc_d     = '0;
               cnt_d     = '0;
            end
         end
         default: begin
            state_d = ENTRY_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign item_select       = sel_q;
   assign item_select_valid = valid_q;
   assign entry_error       = error_q;
   assign entry_timeout     = timeout_q;
   assign entry_active      = (state_q == ENTRY_ACTIVE);
   assign digit_count       = cnt_q;

endmodule

// File: tb/tb_keypad_item_entry.sv
// Directed bench for keypad_item_entry: two instances (1000 and 500 items) share one keypad stream.
module tb_keypad_item_entry;

   localparam int TO = 16;

   typedef struct {
      bit active;
      int acc;
      int cnt;
      int idle;
      int sel;
      bit valid;
      bit err;
      bit tmo;
   } model_t;

   logic       clk;
   logic       rstn;
   logic       key_valid;
   logic [3:0] key_code;

   logic [9:0] sel[2];
   logic       valid[2];
   logic       err[2];
   logic       tmo[2];
   logic       active[2];
   logic [1:0] cnt[2];

   model_t m[2];

   int vectors     = 0;
   int miscompares = 0;

   keypad_item_entry #(
      .ITEM_ADDR_WIDTH(10), .MAX_DIGITS(3), .NUM_ITEMS(1000), .TIMEOUT_CYCLES(TO)
   ) dut_a (
      .clk(clk), .rstn(rstn), .key_valid(key_valid), .key_code(key_code),
      .item_select(sel[0]), .item_select_valid(valid[0]), .entry_error(err[0]),
      .entry_timeout(tmo[0]), .entry_active(active[0]), .digit_count(cnt[0])
   );

   keypad_item_entry #(
      .ITEM_ADDR_WIDTH(10), .MAX_DIGITS(3), .NUM_ITEMS(500), .TIMEOUT_CYCLES(TO)
   ) dut_b (
      .clk(clk), .rstn(rstn), .key_valid(key_valid), .key_code(key_code),
      .item_select(sel[1]), .item_select_valid(valid[1]), .entry_error(err[1]),
      .entry_timeout(tmo[1]), .entry_active(active[1]), .digit_count(cnt[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural view of one entry: value, digit count and consecutive idle cycles.
   function automatic model_t step(model_t s, int num_items, logic kv, logic [3:0] kc);
      model_t n;
      bit is_digit;
      n        = s;
      is_digit = kv && (kc <= 4'd9);
      n.valid  = 0;
      n.err    = 0;
      n.tmo    = 0;
      if (!s.active) begin
         if (is_digit) begin
            n.active = 1; n.acc = int'(kc); n.cnt = 1; n.idle = 0;
         end
      end else if (is_digit && s.cnt < 3) begin
         n.acc = s.acc * 10 + int'(kc); n.cnt = s.cnt + 1; n.idle = 0;
      end else if (kv && kc <= 4'hB) begin
         if (is_digit) n.err = 1;
         else if (kc == 4'hB) begin
            if (s.acc < num_items) begin n.sel = s.acc; n.valid = 1; end
            else n.err = 1;
         end
         n.active = 0; n.acc = 0; n.cnt = 0; n.idle = 0;
      end else begin
         n.idle = s.idle + 1;
         if (n.idle == TO) begin
            n.tmo = 1; n.active = 0; n.acc = 0; n.cnt = 0; n.idle = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 2; i++) m[i] <= '{0, 0, 0, 0, 0, 0, 0, 0};
      end else begin
         m[0] <= step(m[0], 1000, key_valid, key_code);
         m[1] <= step(m[1], 500, key_valid, key_code);
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check_output($sformatf("item_select[%0d]", i), 32'(sel[i]), 32'(m[i].sel));
         check_output($sformatf("valid[%0d]", i), 32'(valid[i]), 32'(m[i].valid));
         check_output($sformatf("error[%0d]", i), 32'(err[i]), 32'(m[i].err));
         check_output($sformatf("timeout[%0d]", i), 32'(tmo[i]), 32'(m[i].tmo));
         check_output($sformatf("active[%0d]", i), 32'(active[i]), 32'(m[i].active));
         check_output($sformatf("digit_count[%0d]", i), 32'(cnt[i]), 32'(m[i].cnt));
      end
   end

   task automatic apply_stimulus(input logic kv, input logic [3:0] kc);
      key_valid = kv;
      key_code  = kc;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 4'h0);
   endtask

   initial begin
      rstn      = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // Reset dropped mid-entry clears everything without waiting for a clock edge.
      apply_stimulus(1'b1, 4'd4);
      apply_stimulus(1'b1, 4'd2);
      check_output("pre_reset_count", 32'(cnt[0]), 32'd2);
      #2 rstn = 1'b0;
      #1;
      check_output("async_active", 32'(active[0]), 32'd0);
      check_output("async_count", 32'(cnt[0]), 32'd0);
      check_output("async_sel", 32'(sel[0]), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      apply_stimulus(1'b1, 4'd1);
      apply_stimulus(1'b1, 4'hB);
      check_output("first_sel", 32'(sel[0]), 32'd1);
      check_output("first_valid", 32'(valid[0]), 32'd1);
      idle(1);
      check_output("first_valid_drop", 32'(valid[0]), 32'd0);

      // Normal entry, one key every third cycle.
      apply_stimulus(1'b1, 4'd1); check_output("cnt_1", 32'(cnt[0]), 32'd1); idle(2);
      apply_stimulus(1'b1, 4'd2); check_output("cnt_2", 32'(cnt[0]), 32'd2); idle(2);
      apply_stimulus(1'b1, 4'd3); check_output("cnt_3", 32'(cnt[0]), 32'd3); idle(2);
      apply_stimulus(1'b1, 4'hB);
      check_output("sel_123", 32'(sel[0]), 32'd123);
      check_output("valid_123", 32'(valid[0]), 32'd1);
      check_output("cnt_after_enter", 32'(cnt[0]), 32'd0);
      idle(2);

      // Range limits: 999 legal everywhere except the 500-item unit.
      apply_stimulus(1'b1, 4'd9); apply_stimulus(1'b1, 4'd9); apply_stimulus(1'b1, 4'd9);
      apply_stimulus(1'b1, 4'hB);
      check_output("sel_999", 32'(sel[0]), 32'd999);
      check_output("err_999_b", 32'(err[1]), 32'd1);
      check_output("hold_b_999", 32'(sel[1]), 32'd123);
      apply_stimulus(1'b1, 4'd5); apply_stimulus(1'b1, 4'd0); apply_stimulus(1'b1, 4'd0);
      apply_stimulus(1'b1, 4'hB);
      check_output("sel_500_a", 32'(sel[0]), 32'd500);
      check_output("err_500_b", 32'(err[1]), 32'd1);
      check_output("valid_500_b", 32'(valid[1]), 32'd0);
      check_output("hold_b_500", 32'(sel[1]), 32'd123);
      idle(2);

      // Over-length entry, then a cleared entry followed by a bare ENTER.
      apply_stimulus(1'b1, 4'd1); apply_stimulus(1'b1, 4'd2);
      apply_stimulus(1'b1, 4'd3); apply_stimulus(1'b1, 4'd4);
      check_output("overlength_err", 32'(err[0]), 32'd1);
      check_output("overlength_idle", 32'(active[0]), 32'd0);
      apply_stimulus(1'b1, 4'd7); apply_stimulus(1'b1, 4'hA); apply_stimulus(1'b1, 4'hB);
      check_output("clear_no_valid", 32'(valid[0]), 32'd0);
      check_output("clear_no_err", 32'(err[0]), 32'd0);
      idle(2);

      // Timeout: key 5, then silence until the timer expires.
      apply_stimulus(1'b1, 4'd5);
      idle(TO - 1);
      check_output("pre_expiry_active", 32'(active[0]), 32'd1);
      check_output("pre_expiry_tmo", 32'(tmo[0]), 32'd0);
      idle(1);
      check_output("expiry_tmo", 32'(tmo[0]), 32'd1);
      check_output("expiry_inactive", 32'(active[0]), 32'd0);
      idle(2);

      // A digit on the expiry cycle beats the timer.
      apply_stimulus(1'b1, 4'd5);
      idle(TO - 1);
      apply_stimulus(1'b1, 4'd3);
      check_output("race_no_tmo", 32'(tmo[0]), 32'd0);
      check_output("race_cnt", 32'(cnt[0]), 32'd2);
      apply_stimulus(1'b1, 4'hB);
      check_output("race_sel", 32'(sel[1]), 32'd53);
      idle(2);

      // Ignored codes do not keep an entry alive.
      apply_stimulus(1'b1, 4'd8);
      for (int i = 0; i < TO; i++) apply_stimulus(1'b1, 4'hC);
      check_output("ignored_tmo", 32'(tmo[0]), 32'd1);
      idle(2);

      // Back-to-back entries with an ignored code in between.
      apply_stimulus(1'b1, 4'd4);
      apply_stimulus(1'b1, 4'hB);
      check_output("b2b_sel_4", 32'(sel[0]), 32'd4);
      apply_stimulus(1'b1, 4'd6);
      check_output("b2b_cnt_6", 32'(cnt[0]), 32'd1);
      apply_stimulus(1'b1, 4'hE);
      check_output("b2b_ignored", 32'(cnt[0]), 32'd1);
      apply_stimulus(1'b1, 4'hB);
      check_output("b2b_sel_6", 32'(sel[0]), 32'd6);
      check_output("b2b_valid_6", 32'(valid[0]), 32'd1);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
